// File: rtl/cm3_matrix_output_arb.sv
// cm3_matrix_output_arb
// Output-port arbiter for one bus-matrix master interface (MI) shared by up to
// three slave-side input ports (SI0..SI2). Registers the address-phase owner
// and the data-phase owner. Grants are held across bursts and locked
// sequences, and ownership moves only on HREADYM-qualified edges.
//
// Parameters:
//   RR_EN          1 = round-robin arbitration, 0 = fixed priority (SI0 highest)
// Ports:
//   HCLK, HRESETn  clock, asynchronous active-low reset
//   HREADYM        HREADY of the output port
//   sel_opN        SIn decoder selects this MI
//   trans_opN      HTRANS presented by SIn
//   burst_opN      HBURST presented by SIn
//   mastlock_opN   HMASTLOCK presented by SIn
//   addr_in_port   registered address-phase owner
//   no_port        registered: no address-phase owner
//   data_in_port   registered data-phase owner
//   data_no_port   registered: data phase belongs to no SI
//   active_opN     SIn currently owns the address phase
module cm3_matrix_output_arb #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       HREADYM,
    input  logic       sel_op0,
    input  logic       sel_op1,
    input  logic       sel_op2,
    input  logic [1:0] trans_op0,
    input  logic [1:0] trans_op1,
    input  logic [1:0] trans_op2,
    input  logic [2:0] burst_op0,
    input  logic [2:0] burst_op1,
    input  logic [2:0] burst_op2,
    input  logic       mastlock_op0,
    input  logic       mastlock_op1,
    input  logic       mastlock_op2,
    output logic [1:0] addr_in_port,
    output logic       no_port,
    output logic [1:0] data_in_port,
    output logic       data_no_port,
    output logic       active_op0,
    output logic       active_op1,
    output logic       active_op2
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;
    localparam logic [2:0] BURST_SINGLE = 3'b000;

    logic [1:0] addr_q, addr_d;
    logic       no_port_q, no_port_d;
    logic [1:0] data_q;
    logic       data_no_q;
    logic [1:0] last_q;

    logic [2:0] req;
    logic [1:0] own_trans;
    logic [2:0] own_burst;
    logic       own_lock;
    logic       owner_valid;
    logic       illegal_owner;
    logic       hold;

    function automatic logic [1:0] next_port(input logic [1:0] p);
        case (p)
            2'd0:    next_port = 2'd1;
            2'd1:    next_port = 2'd2;
            default: next_port = 2'd0;
        endcase
    endfunction

    assign req = {sel_op2 & (trans_op2 != TRANS_IDLE),
                  sel_op1 & (trans_op1 != TRANS_IDLE),
                  sel_op0 & (trans_op0 != TRANS_IDLE)};

    // Transfer attributes of the current address-phase owner
    always_comb begin
        own_trans = TRANS_IDLE;
        own_burst = BURST_SINGLE;
        own_lock  = 1'b0;
        case (addr_q)
            2'd0: begin own_trans = trans_op0; own_burst = burst_op0; own_lock = mastlock_op0; end
            2'd1: begin own_trans = trans_op1; own_burst = burst_op1; own_lock = mastlock_op1; end
            2'd2: begin own_trans = trans_op2; own_burst = burst_op2; own_lock = mastlock_op2; end
            default: ;
        endcase
    end

    assign illegal_owner = ~no_port_q & (addr_q == 2'd3);
    assign owner_valid   = ~no_port_q & ~illegal_owner;

    // A locked owner keeps the grant even while presenting IDLE
    assign hold = owner_valid &
                  (own_lock |
                   (own_trans == TRANS_SEQ) |
                   (own_trans == TRANS_BUSY) |
                   ((own_trans == TRANS_NONSEQ) & (own_burst != BURST_SINGLE)));

    always_comb begin
        logic [1:0] cand;
        logic       found;
        addr_d    = addr_q;
        no_port_d = 1'b1;
        cand      = owner_valid ? addr_q : last_q;
        found     = 1'b0;
        if (illegal_owner) begin
            no_port_d = 1'b1;
        end else if (hold) begin
            no_port_d = 1'b0;
        end else if (RR_EN) begin
            // Search starts one past the current (or last valid) owner and wraps
            for (int unsigned i = 0; i < 3; i++) begin
                cand = next_port(cand);
                if (!found && req[cand]) begin
                    found     = 1'b1;
                    addr_d    = cand;
                    no_port_d = 1'b0;
                end
            end
        end else begin
            if (req[0]) begin
                addr_d    = 2'd0;
                no_port_d = 1'b0;
            end else if (req[1]) begin
                addr_d    = 2'd1;
                no_port_d = 1'b0;
            end else if (req[2]) begin
                addr_d    = 2'd2;
                no_port_d = 1'b0;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q    <= 2'd0;
            no_port_q <= 1'b1;
            data_q    <= 2'd0;
            data_no_q <= 1'b1;
            last_q    <= 2'd2;
        end else if (HREADYM) begin
            addr_q    <= addr_d;
            no_port_q <= no_port_d;
            data_q    <= addr_q;
            data_no_q <= no_port_q | (own_trans == TRANS_IDLE);
            if (owner_valid) begin
                last_q <= addr_q;
            end
        end
    end

    assign addr_in_port = addr_q;
    assign no_port      = no_port_q;
    assign data_in_port = data_q;
    assign data_no_port = data_no_q;
    assign active_op0   = (addr_q == 2'd0) & ~no_port_q;
    assign active_op1   = (addr_q == 2'd1) & ~no_port_q;
    assign active_op2   = (addr_q == 2'd2) & ~no_port_q;

endmodule
